rf_control_fsm: RTL

- Multi-cycle control sequencer directly upstream of the register file.
- Accepts one instruction at a time over a valid/ready handshake and decodes it.
- Drives the RF read addresses, destination selects, source mux select, write address and write enable.
- For ALU instructions, starts the ALU, waits for its done flag, then writes the result back through the RF's C source.

---
 rtl/rf_control_fsm.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rf_control_fsm.sv
// Multi-cycle register-file control sequencer: accepts one instruction, decodes it, runs the ALU if needed, writes back.
// Optional ALU_TIMEOUT_EN: abort EXEC after TIMEOUT cycles without alu_done and raise a sticky err.
module rf_control_fsm #(
  parameter int ADDR_BITS = 2,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2+3*ADDR_BITS-1:0]   instr,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic                       alu_done,
  output logic                       alu_start,
  output logic [ADDR_BITS-1:0]       readAddressA,
  output logic [ADDR_BITS-1:0]       readAddressB,
  output logic                       selectDestinationA,
  output logic                       selectDestinationB,
  output logic [1:0]                 selectSource,
  output logic [ADDR_BITS-1:0]       writeAddress,
  output logic                       write_en,
  output logic                       halted,
  output logic                       err,
  output logic [CNT_W-1:0]           retired_count
);

  localparam int IW = 2 + 3*ADDR_BITS;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

  state_t state, next_state;

  logic [IW-1:0]        ir;
  logic [1:0]           opcode;
  logic [ADDR_BITS-1:0] rd, rs1, rs2;
  logic                 first_exec;
  logic                 timeout_hit;

  assign opcode = ir[IW-1 -: 2];
  assign rd     = ir[3*ADDR_BITS-1 -: ADDR_BITS];
  assign rs1    = ir[2*ADDR_BITS-1 -: ADDR_BITS];
  assign rs2    = ir[ADDR_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && instr_valid)
        ir <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_count <= '0;
    else if (state == S_WRITE)
      retired_count <= retired_count + CNT_W'(1);
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] exec_cnt;

  // exec_cnt holds the 1-based index of the current EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      exec_cnt <= '0;
    else if (state == S_DECODE)
      exec_cnt <= TW'(1);
    else if (state == S_EXEC && exec_cnt != TW'(TIMEOUT))
      exec_cnt <= exec_cnt + TW'(1);
  end

  assign first_exec  = (exec_cnt == TW'(1));
  assign timeout_hit = (exec_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (state == S_EXEC && !alu_done && timeout_hit)
      err <= 1'b1;
  end
`else
  logic exec_first;
  logic unused_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      exec_first <= 1'b0;
    else
      exec_first <= (state == S_DECODE);
  end

  assign first_exec     = exec_first;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (instr_valid) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ALU:  next_state = S_EXEC;
          OP_HALT: next_state = S_HALT;
          default: next_state = S_WRITE;
        endcase
      end
      S_EXEC: begin
        if (alu_done)         next_state = S_WRITE;
        else if (timeout_hit) next_state = S_IDLE;
      end
      S_WRITE:  next_state = S_IDLE;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from state and the latched instruction only
  always_comb begin
    instr_ready        = (state == S_IDLE);
    halted             = (state == S_HALT);
    alu_start          = (state == S_EXEC) && first_exec;
    write_en           = (state == S_WRITE);
    readAddressA       = rs1;
    readAddressB       = rs2;
    writeAddress       = rd;
    selectDestinationA = 1'b0;
    selectDestinationB = 1'b0;
    selectSource       = 2'b11;
    if (state == S_WRITE) begin
      case (opcode)
        OP_LOAD: selectSource = 2'b00;
        OP_MOVE: selectSource = 2'b01;
        OP_ALU:  selectSource = 2'b10;
        default: selectSource = 2'b11;
      endcase
    end
  end

endmodule
